// File: rtl/ps2_key_controller_if.sv
// Key-event handshake between the PS/2 key controller (master) and the game FSM (slave).
// One-deep valid/ready channel carrying a stripped scancode plus extended/release flags.
interface ps2_key_controller_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_release,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_release,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_controller.sv
// Decodes the raw PS/2 byte stream (E0/F0 prefixes, resync timeout) into key events,
// keeps held flags for the four game keys and offers each event over a one-deep channel.
module ps2_key_controller #(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] KEY_LEFT       = 8'h1C,
    parameter logic [7:0] KEY_RIGHT      = 8'h1B,
    parameter logic [7:0] KEY_ENTER      = 8'h5A,
    parameter logic [7:0] KEY_FIRE       = 8'h29
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_i,
    output logic                       rx_en_o,
    input  logic                       rx_done_tick_i,
    input  logic [7:0]                 rx_data_i,
    ps2_key_controller_if.master       ev,
    output logic                       left_o,
    output logic                       right_o,
    output logic                       enter_o,
    output logic                       fire_o,
    output logic                       overflow_o,
    input  logic                       clear_ovf_i
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      KEY_VEC = {KEY_FIRE, KEY_ENTER, KEY_RIGHT, KEY_LEFT};

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           state_q, state_d, eff_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rx_en_q;
    logic [3:0]       held_q;
    logic             ev_valid_q, ev_ext_q, ev_release_q, overflow_q;
    logic [7:0]       ev_code_q;

    logic       byte_v, is_nonkey, timed_out, accept, drop;
    logic       ev_new, new_ext, new_rel;
    logic [3:0] key_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_hit
            assign key_hit[gi] = (rx_data_i == KEY_VEC[gi*8 +: 8]);
        end
    endgenerate

    assign byte_v    = rx_done_tick_i && enable_i;
    assign is_nonkey = rx_data_i inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    // An expired prefix is treated as if the FSM were already back in IDLE, even if a byte lands that cycle.
    assign timed_out = (state_q != IDLE) && (cnt_q == CNT_MAX);
    assign eff_state = timed_out ? IDLE : state_q;
    assign accept    = ev_valid_q && ev.ev_ready;
    assign drop      = ev_new && ev_valid_q && !accept;

    always_comb begin
        state_d = eff_state;
        ev_new  = 1'b0;
        new_ext = 1'b0;
        new_rel = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
        end else if (byte_v) begin
            if (is_nonkey) begin
                state_d = IDLE;
            end else if (rx_data_i == 8'hE0) begin
                // A second E0, or E0 after F0, is a protocol error.
                state_d = (eff_state == IDLE) ? EXT : IDLE;
            end else if (rx_data_i == 8'hF0) begin
                state_d = (eff_state == IDLE) ? BRK :
                          (eff_state == EXT)  ? EXT_BRK : IDLE;
            end else begin
                ev_new  = 1'b1;
                new_ext = (eff_state == EXT) || (eff_state == EXT_BRK);
                new_rel = (eff_state == BRK) || (eff_state == EXT_BRK);
                state_d = IDLE;
            end
        end
        if (state_d == IDLE || byte_v)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rx_en_q      <= 1'b0;
            held_q       <= '0;
            ev_valid_q   <= 1'b0;
            ev_code_q    <= '0;
            ev_ext_q     <= 1'b0;
            ev_release_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_en_q <= enable_i;

            if (!enable_i)
                held_q <= '0;
            else if (ev_new && !new_ext)
                held_q <= (held_q & ~key_hit) | (new_rel ? 4'b0000 : key_hit);

            if (ev_new && (!ev_valid_q || accept)) begin
                ev_valid_q   <= 1'b1;
                ev_code_q    <= rx_data_i;
                ev_ext_q     <= new_ext;
                ev_release_q <= new_rel;
            end else if (accept) begin
                ev_valid_q   <= 1'b0;
                ev_code_q    <= '0;
                ev_ext_q     <= 1'b0;
                ev_release_q <= 1'b0;
            end

            if (drop)
                overflow_q <= 1'b1;
            else if (clear_ovf_i)
                overflow_q <= 1'b0;
        end
    end

    assign rx_en_o       = rx_en_q;
    assign ev.ev_valid   = ev_valid_q;
    assign ev.ev_code    = ev_code_q;
    assign ev.ev_ext     = ev_ext_q;
    assign ev.ev_release = ev_release_q;
    assign left_o        = held_q[0];
    assign right_o       = held_q[1];
    assign enter_o       = held_q[2];
    assign fire_o        = held_q[3];
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Bench for ps2_key_controller: directed scenarios with literal expectations, then random
// byte traffic checked every cycle against a prefix/queue-level reference model.
module tb_ps2_key_controller;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       clear_ovf = 1'b0;
    logic       rx_en, left, right, enter, fire, ovf;

    ps2_key_controller_if ev_if ();

    ps2_key_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .rx_en_o        (rx_en),
        .rx_done_tick_i (rx_done),
        .rx_data_i      (rx_data),
        .ev             (ev_if),
        .left_o         (left),
        .right_o        (right),
        .enter_o        (enter),
        .fire_o         (fire),
        .overflow_o     (ovf),
        .clear_ovf_i    (clear_ovf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: pending prefix flags with the cycle they arrived, a one-slot event holder.
    bit       m_valid, m_ext, m_rel, m_ovf, m_rxen;
    bit [7:0] m_code;
    bit [3:0] m_held;
    bit       p_ext, p_brk;
    int       p_edge;
    int       cyc = 0;
    bit [7:0] keys   [4] = '{8'h1C, 8'h1B, 8'h5A, 8'h29};
    bit [7:0] nonkeys[7] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    function automatic bit is_nonkey(input bit [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

    task automatic model_step();
        bit       acc, have, drop, e, r;
        bit [7:0] b;
        cyc++;
        if (rst) begin
            {m_valid, m_ext, m_rel, m_ovf, m_rxen} = '0;
            m_code = '0; m_held = '0; p_ext = 0; p_brk = 0;
        end else begin
            acc  = m_valid && ev_if.ev_ready;
            have = 0; e = 0; r = 0; b = rx_data;
            if (!enable) begin
                p_ext = 0; p_brk = 0; m_held = '0;
            end else if (rx_done) begin
                if ((p_ext || p_brk) && (cyc - p_edge >= T)) begin
                    p_ext = 0; p_brk = 0;
                end
                if (is_nonkey(b)) begin
                    p_ext = 0; p_brk = 0;
                end else if (b == 8'hE0) begin
                    if (p_ext || p_brk) begin p_ext = 0; p_brk = 0; end
                    else begin p_ext = 1; p_edge = cyc; end
                end else if (b == 8'hF0) begin
                    if (p_brk) begin p_ext = 0; p_brk = 0; end
                    else begin p_brk = 1; p_edge = cyc; end
                end else begin
                    have = 1; e = p_ext; r = p_brk;
                    p_ext = 0; p_brk = 0;
                    if (!e)
                        for (int k = 0; k < 4; k++)
                            if (b == keys[k]) m_held[k] = !r;
                end
            end
            drop = have && m_valid && !acc;
            if (have && !drop) begin
                m_valid = 1; m_code = b; m_ext = e; m_rel = r;
            end else if (!have && acc) begin
                m_valid = 0; m_code = '0; m_ext = 0; m_rel = 0;
            end
            if (drop) m_ovf = 1;
            else if (clear_ovf) m_ovf = 0;
            m_rxen = enable;
        end
    endtask

    initial begin
        logic [16:0] got, exp;
        forever begin
            @(posedge clk);
            model_step();
            #2;
            got = {rx_en, ev_if.ev_valid, ev_if.ev_code, ev_if.ev_ext, ev_if.ev_release,
                   left, right, enter, fire, ovf};
            exp = {m_rxen, m_valid, m_code, m_ext, m_rel,
                   m_held[0], m_held[1], m_held[2], m_held[3], m_ovf};
            n_total++;
            if (got === exp) n_pass++;
            else $display("FAIL cycle %0d model: got %h expected %h", cyc, got, exp);
        end
    end

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    function automatic logic [16:0] evv();
        return 17'({ev_if.ev_valid, ev_if.ev_code, ev_if.ev_ext, ev_if.ev_release});
    endfunction

    function automatic logic [16:0] held();
        return 17'({left, right, enter, fire});
    endfunction

    function automatic logic [16:0] all_out();
        return {rx_en, ev_if.ev_valid, ev_if.ev_code, ev_if.ev_ext, ev_if.ev_release,
                left, right, enter, fire, ovf};
    endfunction

    initial begin
        logic [7:0] b;
        int         r;
        ev_if.ev_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        enable = 1'b1;
        check("reset_state", all_out(), 17'h0);
        idle(1);
        check("rx_en_after_reset", 17'(rx_en), 17'h1);
        ev_if.ev_ready = 1'b1;

        // 1: make/break of LEFT
        send(8'h1C);
        check("t1_make_ev", evv(), 17'({1'b1, 8'h1C, 1'b0, 1'b0}));
        check("t1_left_set", held(), 17'b1000);
        send(8'hF0);
        check("t1_accepted", evv(), 17'h0);
        send(8'h1C);
        check("t1_break_ev", evv(), 17'({1'b1, 8'h1C, 1'b0, 1'b1}));
        check("t1_left_clr", held(), 17'b0000);

        // 2: extended make/break never touches held flags
        send(8'hE0); send(8'h75);
        check("t2_ext_make", evv(), 17'({1'b1, 8'h75, 1'b1, 1'b0}));
        send(8'hE0); send(8'hF0); send(8'h75);
        check("t2_ext_break", evv(), 17'({1'b1, 8'h75, 1'b1, 1'b1}));
        check("t2_held", held(), 17'b0000);

        // 3: overflow on a second event with no accept
        idle(1);
        ev_if.ev_ready = 1'b0;
        send(8'h5A);
        check("t3_first", evv(), 17'({1'b1, 8'h5A, 1'b0, 1'b0}));
        send(8'h29);
        check("t3_held_ev", evv(), 17'({1'b1, 8'h5A, 1'b0, 1'b0}));
        check("t3_ovf", 17'(ovf), 17'h1);
        check("t3_enter_fire", held(), 17'b0011);
        ev_if.ev_ready = 1'b1;
        idle(1);
        check("t3_drained", 17'(ev_if.ev_valid), 17'h0);
        clear_ovf = 1'b1;
        idle(1);
        clear_ovf = 1'b0;
        check("t3_ovf_clr", 17'(ovf), 17'h0);

        // 4: F0 times out, following byte is a make
        send(8'hF0);
        idle(T + 2);
        send(8'h1B);
        check("t4_make", evv(), 17'({1'b1, 8'h1B, 1'b0, 1'b0}));
        check("t4_right", 17'(right), 17'h1);

        // 5: non-key bytes are discarded and cancel prefixes
        send(8'hAA); check("t5_aa", 17'(ev_if.ev_valid), 17'h0);
        send(8'hFA); check("t5_fa", 17'(ev_if.ev_valid), 17'h0);
        send(8'hE0); check("t5_e0", 17'(ev_if.ev_valid), 17'h0);
        send(8'hFA); check("t5_fa2", 17'(ev_if.ev_valid), 17'h0);
        send(8'h1C);
        check("t5_make", evv(), 17'({1'b1, 8'h1C, 1'b0, 1'b0}));
        check("t5_left", 17'(left), 17'h1);

        // 6: disable gates receiver and clears held flags; async reset mid-prefix
        send(8'h1C);
        enable = 1'b0;
        idle(1);
        check("t6_rx_en", 17'(rx_en), 17'h0);
        check("t6_held", held(), 17'b0000);
        send(8'h1C); send(8'hF0);
        check("t6_ignored", 17'(ev_if.ev_valid), 17'h0);
        check("t6_held2", held(), 17'b0000);
        enable = 1'b1;
        idle(2);
        send(8'hE0);
        #3 rst = 1'b1;
        #1 check("t6_async_rst", all_out(), 17'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        send(8'h1C);
        check("t6_fresh", evv(), 17'({1'b1, 8'h1C, 1'b0, 1'b0}));

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rx_done = 1'b0;
            clear_ovf = ($urandom_range(0, 49) == 0);
            ev_if.ev_ready = ($urandom_range(0, 3) != 0);
            if (enable ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 4) == 0))
                enable = !enable;
            r = $urandom_range(0, 99);
            if (r < 30) begin
                case ($urandom_range(0, 9))
                    0, 1:    b = 8'hE0;
                    2, 3:    b = 8'hF0;
                    4, 5, 6: b = keys[$urandom_range(0, 3)];
                    7:       b = nonkeys[$urandom_range(0, 6)];
                    default: b = 8'($urandom_range(0, 255));
                endcase
                if (b == 8'hE0 && p_brk && !p_ext) b = 8'h1C;
                rx_data = b;
                rx_done = 1'b1;
            end else if (r < 32) begin
                repeat ($urandom_range(T - 3, T + 3)) @(negedge clk);
            end
        end
        @(negedge clk);
        rx_done = 1'b0;
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
